// File: rtl/bsg_wormhole_router_input_route_hold.sv
// Wormhole router input-side route holder.
// Decodes the length of the header flit at the input FIFO head, requests the
// decoded output port for the header, and keeps requesting that same port for
// every body flit until the tail is consumed. The output arbiters use
// release_o to learn when the held port may be re-arbitrated.
module bsg_wormhole_router_input_route_hold #(
    parameter int flit_width_p = 16,
    parameter int cord_width_p = 5,
    parameter int len_width_p  = 4,
    parameter int dims_p       = 2,
    localparam int dirs_lp     = 2*dims_p+1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    fifo_v_i,
    input  logic [flit_width_p-1:0] fifo_data_i,
    input  logic [dirs_lp-1:0]      decoded_dir_i,
    input  logic                    yumi_i,
    output logic [dirs_lp-1:0]      reqs_o,
    output logic                    release_o,
    output logic                    detected_header_o
);

    typedef enum logic {
        HEADER = 1'b0,
        BODY   = 1'b1
    } state_e;

    state_e                 r_state;
    logic [len_width_p-1:0] r_count;
    logic [dirs_lp-1:0]     r_held_dir;

    logic [len_width_p-1:0] w_len;
    logic                   w_len_zero;
    logic                   w_last_body;
    logic                   w_unused_data;

    // Only the length field matters here; the coordinate was already decoded
    // upstream into decoded_dir_i, and the payload bits are don't-care.
    assign w_len         = fifo_data_i[cord_width_p+len_width_p-1:cord_width_p];
    assign w_len_zero    = (w_len == '0);
    assign w_last_body   = (r_count == len_width_p'(1));
    assign w_unused_data = ^fifo_data_i;

    // Request/release/header-detect outputs, zero-latency from the FIFO head.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // branches below can leave one unassigned and infer a latch.
        reqs_o            = '0;
        release_o         = 1'b0;
        detected_header_o = 1'b0;
        if (!reset_i && fifo_v_i) begin
            if (r_state == HEADER) begin
                reqs_o            = decoded_dir_i;
                detected_header_o = 1'b1;
                release_o         = yumi_i && w_len_zero;
            end else begin
                // Body flits carry no coordinate; decoded_dir_i is garbage here.
                reqs_o    = r_held_dir;
                release_o = yumi_i && w_last_body;
            end
        end
    end

    // Packet tracking: latch route and length on header, count down bodies.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignment so every register
        // samples the pre-edge values regardless of statement order.
        if (reset_i) begin
            r_state    <= HEADER;
            r_count    <= '0;
            r_held_dir <= '0;
        end else if (yumi_i) begin
            if (r_state == HEADER) begin
                r_held_dir <= decoded_dir_i;
                r_count    <= w_len;
                // Zero-length packets are a single flit and never leave HEADER.
                if (!w_len_zero) begin
                    r_state <= BODY;
                end
            end else begin
                r_count <= r_count - len_width_p'(1);
                if (w_last_body) begin
                    r_state <= HEADER;
                end
            end
        end
    end

    // Consuming a flit that is not present is a protocol error upstream.
    a_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (reset_i) !(yumi_i && !fifo_v_i)
    ) else $error("yumi_i asserted while fifo_v_i is low");

    // A valid header must map to exactly one output port.
    a_header_dir_onehot: assert property (
        @(posedge clk_i) disable iff (reset_i)
        (fifo_v_i && r_state == HEADER) |-> $onehot(decoded_dir_i)
    ) else $error("decoded_dir_i not one-hot on a valid header");

    // Requests must never target more than one output port.
    a_reqs_onehot0: assert property (
        @(posedge clk_i) $onehot0(reqs_o)
    ) else $error("reqs_o not one-hot or zero");

endmodule

// File: tb/tb_bsg_wormhole_router_input_route_hold.sv
// Directed bench for bsg_wormhole_router_input_route_hold.
// Inputs change 1 time unit after each rising edge; the combinational outputs
// are compared 1 unit later, well away from the next edge.
module tb_bsg_wormhole_router_input_route_hold;

    localparam int FW = 16;
    localparam int DW = 5;

    localparam logic [DW-1:0] P    = 5'b00001;
    localparam logic [DW-1:0] W    = 5'b00010;
    localparam logic [DW-1:0] E    = 5'b00100;
    localparam logic [DW-1:0] N    = 5'b01000;
    localparam logic [DW-1:0] S    = 5'b10000;
    localparam logic [DW-1:0] NONE = 5'b00000;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          fifo_v_i;
    logic [FW-1:0] fifo_data_i;
    logic [DW-1:0] decoded_dir_i;
    logic          yumi_i;
    logic [DW-1:0] reqs_o;
    logic          release_o;
    logic          detected_header_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bsg_wormhole_router_input_route_hold dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .fifo_v_i          (fifo_v_i),
        .fifo_data_i       (fifo_data_i),
        .decoded_dir_i     (decoded_dir_i),
        .yumi_i            (yumi_i),
        .reqs_o            (reqs_o),
        .release_o         (release_o),
        .detected_header_o (detected_header_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, compare outputs, then advance past the edge.
    task automatic cyc(input string tag, input logic v, input logic [3:0] len,
                       input logic [DW-1:0] dir, input logic y,
                       input logic [DW-1:0] exp_req, input logic exp_rel,
                       input logic exp_det);
        fifo_v_i      = v;
        fifo_data_i   = {7'h55, len, 5'b10110};
        decoded_dir_i = dir;
        yumi_i        = y;
        #1;
        check({tag, ".reqs"},    32'(reqs_o),            32'(exp_req));
        check({tag, ".release"}, 32'(release_o),         32'(exp_rel));
        check({tag, ".header"},  32'(detected_header_o), 32'(exp_det));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        // Outputs forced low during reset even with a valid head flit.
        cyc("rst0", 1, 4'd0, E, 0, NONE, 0, 0);
        cyc("rst1", 1, 4'd3, W, 0, NONE, 0, 0);
        reset_i = 1'b0;

        // Single-flit packet to E.
        cyc("len0_hdr", 1, 4'd0, E, 1, E, 1, 1);
        cyc("len0_idle", 0, 4'd0, E, 0, NONE, 0, 0);
        cyc("len0_still_hdr", 1, 4'd5, S, 0, S, 0, 1);

        // len=3 to W; body flits present garbage on decoded_dir_i.
        cyc("w_hdr", 1, 4'd3, W, 1, W, 0, 1);
        cyc("w_b1", 1, 4'd9, S, 1, W, 0, 0);
        cyc("w_b2", 1, 4'd1, 5'b11111, 1, W, 0, 0);
        cyc("w_b3", 1, 4'd0, 5'b01100, 1, W, 1, 0);
        cyc("w_after", 1, 4'd0, P, 0, P, 0, 1);

        // len=2 to N with three-cycle bubbles between bodies.
        cyc("n_hdr", 1, 4'd2, N, 1, N, 0, 1);
        for (int i = 0; i < 3; i++) cyc("n_gap1", 0, 4'd0, P, 0, NONE, 0, 0);
        cyc("n_b1", 1, 4'd0, P, 1, N, 0, 0);
        for (int i = 0; i < 3; i++) cyc("n_gap2", 0, 4'd0, P, 0, NONE, 0, 0);
        cyc("n_b2", 1, 4'd0, P, 1, N, 1, 0);

        // len=2 to S, body stalled for five cycles with no yumi.
        cyc("s_hdr", 1, 4'd2, S, 1, S, 0, 1);
        for (int i = 0; i < 5; i++) cyc("s_stall", 1, 4'd7, W, 0, S, 0, 0);
        cyc("s_b1", 1, 4'd0, W, 1, S, 0, 0);
        cyc("s_b2", 1, 4'd0, W, 1, S, 1, 0);

        // Maximum length packet: 15 bodies, release only on the last.
        cyc("max_hdr", 1, 4'd15, W, 1, W, 0, 1);
        for (int i = 1; i < 15; i++) cyc("max_body", 1, 4'd0, N, 1, W, 0, 0);
        cyc("max_tail", 1, 4'd0, N, 1, W, 1, 0);
        cyc("max_after", 1, 4'd0, E, 0, E, 0, 1);

        // Reset mid-packet: len=15 to E, four bodies, then reset.
        cyc("mid_hdr", 1, 4'd15, E, 1, E, 0, 1);
        for (int i = 0; i < 4; i++) cyc("mid_body", 1, 4'd0, S, 1, E, 0, 0);
        reset_i = 1'b1;
        cyc("mid_rst0", 1, 4'd0, S, 0, NONE, 0, 0);
        cyc("mid_rst1", 1, 4'd0, W, 0, NONE, 0, 0);
        reset_i = 1'b0;
        cyc("post_rst_hdr", 1, 4'd0, N, 1, N, 1, 1);

        // Back-to-back: len=1 to E then len=0 to P with no bubble.
        cyc("b2b_hdr", 1, 4'd1, E, 1, E, 0, 1);
        cyc("b2b_body", 1, 4'd0, P, 1, E, 1, 0);
        cyc("b2b_next", 1, 4'd0, P, 1, P, 1, 1);
        cyc("b2b_idle", 0, 4'd0, P, 0, NONE, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_wormhole_router_input_route_hold.md
BSG_WORMHOLE_ROUTER_INPUT_ROUTE_HOLD -- requirements
Module: bsg_wormhole_router_input_route_hold

Interface
REQ-001 Parameter flit_width_p, default 16, width of one flit.
REQ-002 Parameter cord_width_p, default 5, width of the destination coordinate field in flit bits [cord_width_p-1:0].
REQ-003 Parameter len_width_p, default 4, width of the length field in flit bits [cord_width_p+len_width_p-1:cord_width_p]; length = number of flits following the header.
REQ-004 Parameter dims_p, default 2; localparam dirs_lp = 2*dims_p+1 (P,W,E,N,S order for dims_p=2).
REQ-005 clk_i  input  1  clock; all state updates on rising edge.
REQ-006 reset_i  input  1  reset, synchronous, active-high.
REQ-007 fifo_v_i  input  1  input FIFO head flit valid.
REQ-008 fifo_data_i  input  flit_width_p  input FIFO head flit.
REQ-009 decoded_dir_i  input  dirs_lp  one-hot route from the dimension-ordered decoder for the coordinate in fifo_data_i.
REQ-010 yumi_i  input  1  head flit consumed this cycle by the granted output port.
REQ-011 reqs_o  output  dirs_lp  one-hot request to output-port arbiters.
REQ-012 release_o  output  1  packet tail consumed; output port may re-arbitrate next cycle.
REQ-013 detected_header_o  output  1  head flit is a valid header.

Function
REQ-014 Block SHALL hold two states: HEADER (next flit is a header) and BODY (remaining count > 0).
REQ-015 In HEADER, detected_header_o SHALL equal fifo_v_i; in BODY it SHALL be 0.
REQ-016 In HEADER, reqs_o SHALL equal decoded_dir_i gated by fifo_v_i (combinational, zero latency).
REQ-017 On HEADER and yumi_i, block SHALL register decoded_dir_i into held_dir_r and length field into count_r.
REQ-018 Header length 0 SHALL be a single-flit packet: release_o=1 that cycle, state stays HEADER, count_r unchanged in effect.
REQ-019 Header length L>0 SHALL move state to BODY with count_r=L next cycle; release_o=0.
REQ-020 In BODY, reqs_o SHALL equal held_dir_r gated by fifo_v_i; decoded_dir_i SHALL be ignored.
REQ-021 In BODY, each yumi_i SHALL decrement count_r by 1; when count_r==1 and yumi_i, release_o=1 and state returns to HEADER next cycle.
REQ-022 release_o SHALL be combinational, asserted only in a cycle where yumi_i=1.
REQ-023 With fifo_v_i=0, reqs_o SHALL be all zeros and state/count SHALL hold; bubbles between body flits SHALL not break the route.
REQ-024 yumi_i with fifo_v_i=0 is illegal; simulation-only assertion SHALL flag it.
REQ-025 decoded_dir_i not one-hot on a valid header SHALL be flagged by simulation-only assertion.
REQ-026 Maximum length 2^len_width_p-1 SHALL be supported with no counter wrap.
REQ-027 reqs_o SHALL be one-hot or zero at all times.

Reset
REQ-028 While reset_i=1 on a clock edge, state SHALL become HEADER, count_r=0, held_dir_r=0.
REQ-029 During reset, reqs_o, release_o, detected_header_o SHALL be 0 regardless of fifo_v_i.
REQ-030 Reset asserted mid-packet (BODY) SHALL discard the remaining count; first valid flit after reset SHALL be treated as a header.

Verification
REQ-031 Header len=0, decoded_dir_i=5'b00100, fifo_v_i=1, yumi_i=1 -> reqs_o=00100, release_o=1, detected_header_o=1, next state HEADER.
REQ-032 Header len=3 to W (00010) then three body flits with decoded_dir_i driven to garbage -> reqs_o=00010 all four flits, release_o=1 only on fourth yumi.
REQ-033 Header len=2, body flits separated by 3 idle cycles (fifo_v_i=0) -> reqs_o=0 during idles, route held, release on second body yumi.
REQ-034 fifo_v_i=1, yumi_i=0 for 5 cycles in BODY -> reqs_o stable, count_r unchanged.
REQ-035 Reset pulsed after header len=15 plus 4 bodies -> outputs 0 during reset; next flit (len=0, to N) -> reqs_o=01000, release_o=1.
REQ-036 Back-to-back packets: len=1 to E then immediately len=0 to P -> release_o on cycles 2 and 3, reqs_o switches 00100 to 00001 with no bubble.
